// File: rtl/mouse_spinner_encoder_pkg.sv
// Shared types and Gray-code helper for the mouse-driven quadrature spinner.
// Also used by the paddle/trackball encoders built on spinner_prescaler.
package spinner_pkg;

    typedef logic [1:0] quad_t;

    localparam quad_t QUAD_RESET = 2'b11;

    // Which way the AB output moves on a given cycle.
    typedef enum logic [1:0] {
        SPIN_HOLD = 2'b00,
        SPIN_POS  = 2'b01,
        SPIN_NEG  = 2'b10
    } spin_dir_t;

    // dir_neg=1 walks 00->01->11->10->00; dir_neg=0 walks 00->10->11->01->00.
    function automatic quad_t quad_next(quad_t q, logic dir_neg);
        quad_t n;
        if (dir_neg) begin
            case (q)
                2'b00:   n = 2'b01;
                2'b01:   n = 2'b11;
                2'b11:   n = 2'b10;
                default: n = 2'b00;
            endcase
        end else begin
            case (q)
                2'b00:   n = 2'b10;
                2'b10:   n = 2'b11;
                2'b11:   n = 2'b01;
                default: n = 2'b00;
            endcase
        end
        return n;
    endfunction

endpackage

// File: rtl/mouse_spinner_encoder_prescaler.sv
// Free-running divide-by-STEP_DIV counter producing a one-cycle step tick.
// Shared by the spinner, paddle and trackball encoders.
module spinner_prescaler #(
    parameter int STEP_DIV = 1000
) (
    input  logic clk_sys,
    input  logic reset,
    output logic tick
);

    localparam int CNT_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_DIV - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        tick    = (count_q == LAST);
        count_d = tick ? '0 : count_q + 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mouse_spinner_encoder.sv
// PS/2 mouse X motion -> saturating position accumulator -> paced AB quadrature spinner.
// Optional macro SPINNER_JOY_EN adds joy_left/joy_right stepping while the accumulator is idle.
module mouse_spinner_encoder
    import spinner_pkg::*;
#(
    parameter int POS_W      = 12,
    parameter int STEP_DIV   = 1000,
    parameter int SENS_SHIFT = 0
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic [24:0]      ps2_mouse,
    input  logic             reverse,
`ifdef SPINNER_JOY_EN
    input  logic             joy_left,
    input  logic             joy_right,
`endif
    output logic [1:0]       spinner,
    output logic             busy,
    output logic [POS_W-1:0] position
);

    // Two guard bits let the raw sum overflow before it is clamped.
    localparam int SUM_W = POS_W + 2;
    localparam logic signed [SUM_W-1:0] POS_MAX = SUM_W'((1 << (POS_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] POS_MIN = -POS_MAX;

    logic                    tick;
    logic                    toggle_q, toggle_d;
    logic signed [POS_W-1:0] position_q, position_d;
    quad_t                   spinner_q, spinner_d;
    logic                    busy_q, busy_d;

    logic                    new_pkt;
    logic signed [8:0]       dx_raw;
    logic signed [POS_W-1:0] dx_base;
    logic signed [POS_W-1:0] dx_scaled;
    logic signed [SUM_W-1:0] pkt_term;
    logic signed [SUM_W-1:0] step_term;
    logic signed [SUM_W-1:0] pos_ext;
    logic signed [SUM_W-1:0] sum;
    spin_dir_t               spin_dir;

    logic unused_mouse_bits;
    assign unused_mouse_bits = ^{ps2_mouse[23:16], ps2_mouse[7:5], ps2_mouse[3:0]};

    spinner_prescaler #(
        .STEP_DIV (STEP_DIV)
    ) u_prescaler (
        .clk_sys (clk_sys),
        .reset   (reset),
        .tick    (tick)
    );

    always_comb begin
        toggle_d  = ps2_mouse[24];
        new_pkt   = (ps2_mouse[24] != toggle_q);

        dx_raw    = {ps2_mouse[4], ps2_mouse[15:8]};
        dx_base   = {{(POS_W - 9){dx_raw[8]}}, dx_raw};
        dx_scaled = dx_base <<< SENS_SHIFT;
        pkt_term  = '0;
        if (new_pkt) begin
            // Negating after widening keeps the most-negative delta representable.
            pkt_term = reverse ? -{{2{dx_scaled[POS_W-1]}}, dx_scaled}
                               :  {{2{dx_scaled[POS_W-1]}}, dx_scaled};
        end

        // Step direction follows the pre-update position.
        spin_dir  = SPIN_HOLD;
        step_term = '0;
        if (tick && (position_q != '0)) begin
            if (position_q[POS_W-1]) begin
                spin_dir  = SPIN_NEG;
                step_term = SUM_W'(1);
            end else begin
                spin_dir  = SPIN_POS;
                step_term = '1;
            end
        end
`ifdef SPINNER_JOY_EN
        else if (tick) begin
            if ((reverse ? joy_left : joy_right) && !(reverse ? joy_right : joy_left)) begin
                spin_dir = SPIN_POS;
            end else if ((reverse ? joy_right : joy_left) && !(reverse ? joy_left : joy_right)) begin
                spin_dir = SPIN_NEG;
            end
        end
`endif

        pos_ext = {{2{position_q[POS_W-1]}}, position_q};
        sum     = pos_ext + pkt_term + step_term;

        if (sum > POS_MAX) begin
            position_d = POS_MAX[POS_W-1:0];
        end else if (sum < POS_MIN) begin
            position_d = POS_MIN[POS_W-1:0];
        end else begin
            position_d = sum[POS_W-1:0];
        end

        busy_d    = (position_d != '0);
        spinner_d = (spin_dir == SPIN_HOLD) ? spinner_q
                                            : quad_next(spinner_q, spin_dir == SPIN_NEG);
    end

    // NOTE: the toggle flop loads the live packet bit during reset so no packet is seen on release.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            toggle_q   <= ps2_mouse[24];
            position_q <= '0;
            spinner_q  <= QUAD_RESET;
            busy_q     <= 1'b0;
        end else begin
            toggle_q   <= toggle_d;
            position_q <= position_d;
            spinner_q  <= spinner_d;
            busy_q     <= busy_d;
        end
    end

    assign spinner  = spinner_q;
    assign busy     = busy_q;
    assign position = position_q;

endmodule

// File: tb/tb_mouse_spinner_encoder.sv
// Directed bench for mouse_spinner_encoder: fast-tick instance for stepping, stalled instance for saturation.
module tb_mouse_spinner_encoder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [24:0] ps2_mouse = '0;
    logic        reverse = 1'b0;
    logic        joy_left = 1'b0;
    logic        joy_right = 1'b0;
    logic        tgl = 1'b0;

    logic [1:0]  spin_f, spin_s;
    logic        busy_f, busy_s;
    logic [11:0] pos_f, pos_s;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    mouse_spinner_encoder #(.POS_W(12), .STEP_DIV(4), .SENS_SHIFT(0)) dut (
        .clk_sys   (clk),
        .reset     (reset),
        .ps2_mouse (ps2_mouse),
        .reverse   (reverse),
`ifdef SPINNER_JOY_EN
        .joy_left  (joy_left),
        .joy_right (joy_right),
`endif
        .spinner   (spin_f),
        .busy      (busy_f),
        .position  (pos_f)
    );

    mouse_spinner_encoder #(.POS_W(12), .STEP_DIV(5000), .SENS_SHIFT(0)) dut_sat (
        .clk_sys   (clk),
        .reset     (reset),
        .ps2_mouse (ps2_mouse),
        .reverse   (reverse),
`ifdef SPINNER_JOY_EN
        .joy_left  (1'b0),
        .joy_right (1'b0),
`endif
        .spinner   (spin_s),
        .busy      (busy_s),
        .position  (pos_s)
    );

    task automatic tick_clk();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick_clk();
    endtask

    // Reset spans two edges; cyc=0 marks the last reset edge, so step ticks land on cyc 4, 8, 12...
    task automatic do_reset();
        reset = 1'b1;
        tick_clk();
        tick_clk();
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic send(input int dx);
        logic [8:0] v;
        v = 9'(dx);
        tgl = ~tgl;
        ps2_mouse = '0;
        ps2_mouse[24]   = tgl;
        ps2_mouse[4]    = v[8];
        ps2_mouse[15:8] = v[7:0];
    endtask

    task automatic chk_f(input string name, input logic [1:0] exp_spin, input int exp_pos, input logic exp_busy);
        total_cnt++;
        if (spin_f !== exp_spin || int'($signed(pos_f)) != exp_pos || busy_f !== exp_busy)
            $display("FAIL %s cyc=%0d: spinner=%b pos=%0d busy=%b, expected spinner=%b pos=%0d busy=%b",
                     name, cyc, spin_f, $signed(pos_f), busy_f, exp_spin, exp_pos, exp_busy);
        else
            pass_cnt++;
    endtask

    task automatic test_reset();
        tgl = 1'b1;
        ps2_mouse = 25'h1000000;
        do_reset();
        chk_f("reset_state", 2'b11, 0, 1'b0);
        run_to(3);
        chk_f("no_phantom_packet", 2'b11, 0, 1'b0);
    endtask

    task automatic test_positive_drain();
        logic [1:0] es [4] = '{2'b01, 2'b00, 2'b10, 2'b10};
        int         ep [4] = '{2, 1, 0, 0};
        logic       eb [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        do_reset();
        send(3);
        tick_clk();
        chk_f("pos_pkt_latency", 2'b11, 3, 1'b1);
        for (int i = 0; i < 4; i++) begin
            run_to(4 * (i + 1));
            chk_f("pos_drain_step", es[i], ep[i], eb[i]);
        end
    endtask

    task automatic test_negative_drain();
        do_reset();
        send(-2);
        tick_clk();
        chk_f("neg_pkt_latency", 2'b11, -2, 1'b1);
        run_to(4);
        chk_f("neg_step1", 2'b10, -1, 1'b1);
        run_to(8);
        chk_f("neg_step2", 2'b00, 0, 1'b0);
        run_to(12);
        chk_f("neg_hold", 2'b00, 0, 1'b0);
    endtask

    task automatic test_reverse();
        reverse = 1'b1;
        do_reset();
        send(2);
        tick_clk();
        chk_f("rev_pkt", 2'b11, -2, 1'b1);
        run_to(4);
        chk_f("rev_step1", 2'b10, -1, 1'b1);
        run_to(8);
        chk_f("rev_step2", 2'b00, 0, 1'b0);
        reverse = 1'b0;
    endtask

    task automatic test_zero_packet();
        do_reset();
        send(0);
        tick_clk();
        chk_f("zero_pkt", 2'b11, 0, 1'b0);
        run_to(4);
        chk_f("zero_pkt_tick", 2'b11, 0, 1'b0);
    endtask

    task automatic test_tick_collision();
        do_reset();
        send(1);
        run_to(3);
        chk_f("collide_pre", 2'b11, 1, 1'b1);
        send(4);
        tick_clk();
        chk_f("collide_on_tick", 2'b01, 4, 1'b1);
    endtask

    task automatic test_reversal_mid_drain();
        do_reset();
        send(5);
        run_to(4);
        chk_f("mid_drain_pos", 2'b01, 4, 1'b1);
        send(-8);
        tick_clk();
        chk_f("mid_drain_flip", 2'b01, -4, 1'b1);
        run_to(8);
        chk_f("mid_drain_neg_step", 2'b11, -3, 1'b1);
    endtask

    task automatic test_saturation();
        int exp_pos;
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            send(127);
            tick_clk();
            exp_pos = (127 * k > 2047) ? 2047 : 127 * k;
            total_cnt++;
            if (int'($signed(pos_s)) != exp_pos || busy_s !== 1'b1 || spin_s !== 2'b11)
                $display("FAIL sat_pos k=%0d: pos=%0d busy=%b spinner=%b, expected pos=%0d busy=1 spinner=11",
                         k, $signed(pos_s), busy_s, spin_s, exp_pos);
            else
                pass_cnt++;
        end
        do_reset();
        for (int k = 1; k <= 17; k++) begin
            send(-128);
            tick_clk();
            exp_pos = (-128 * k < -2047) ? -2047 : -128 * k;
            total_cnt++;
            if (int'($signed(pos_s)) != exp_pos)
                $display("FAIL sat_neg k=%0d: pos=%0d, expected %0d", k, $signed(pos_s), exp_pos);
            else
                pass_cnt++;
        end
    endtask

`ifdef SPINNER_JOY_EN
    task automatic test_joy();
        logic [1:0] es [3] = '{2'b01, 2'b00, 2'b10};
        do_reset();
        joy_right = 1'b1;
        for (int i = 0; i < 3; i++) begin
            run_to(4 * (i + 1));
            chk_f("joy_right_step", es[i], 0, 1'b0);
        end
        joy_left = 1'b1;
        run_to(16);
        chk_f("joy_both_hold", 2'b10, 0, 1'b0);
        joy_left  = 1'b0;
        joy_right = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_positive_drain();
        test_negative_drain();
        test_reverse();
        test_zero_packet();
        test_tick_collision();
        test_reversal_mid_drain();
        test_saturation();
`ifdef SPINNER_JOY_EN
        test_joy();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
